// File: rtl/acia_pkg.sv
// ============================================================================
// acia_pkg : shared types, field encodings and frame-timing helpers for the
//            ACIA transmitter.  Rev 1.0
// ============================================================================
`default_nettype none

package acia_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  localparam logic [1:0] WL_8 = 2'b00;
  localparam logic [1:0] WL_7 = 2'b01;
  localparam logic [1:0] WL_6 = 2'b10;
  localparam logic [1:0] WL_5 = 2'b11;

  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1P5 = 2'd1,
    STOP_2   = 2'd2
  } stop_sel_t;

  function automatic stop_sel_t stop_sel(input logic sbn, input logic [1:0] wl,
                                         input logic pme);
    if (!sbn)                    return STOP_1;
    else if (wl == WL_8 && pme)  return STOP_1;
    else if (wl == WL_5 && !pme) return STOP_1P5;
    else                         return STOP_2;
  endfunction

  function automatic int unsigned stop_ticks(input logic sbn, input logic [1:0] wl,
                                             input logic pme, input int unsigned os);
    case (stop_sel(sbn, wl, pme))
      STOP_1:   return os;
      STOP_1P5: return (3 * os) / 2;
      default:  return 2 * os;
    endcase
  endfunction

  function automatic logic [3:0] nbits_from_wl(input logic [1:0] wl);
    return 4'd8 - {2'b00, wl};
  endfunction

endpackage

`default_nettype wire

// File: rtl/acia_sync_fifo.sv
// ============================================================================
// acia_sync_fifo : single-clock FIFO with registered full/empty/level flags.
//                  Rev 1.0
// ============================================================================
`default_nettype none

module acia_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_full;
  logic             r_empty;
  logic             w_do_pop;
  logic             w_do_push;
  logic [LVL_W-1:0] w_level_nxt;

  // A push into a full FIFO is still legal when a pop frees a slot this cycle.
  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_do_push, w_do_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_W'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/acia_tx_fifo.sv
// ============================================================================
// acia_tx_fifo : FIFO-fed async serialiser (5-8 bits, parity, 1/1.5/2 stop).
//                Break generation is built only with ACIA_TX_BREAK_EN defined.
//                Rev 1.0
// ============================================================================
`default_nettype none

module acia_tx_fifo
  import acia_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             PHI2,
  input  logic             RESET,
  input  logic             BCLK_EN,
  input  logic             CTSB,
  input  logic [7:0]       TXDATA,
  input  logic             TXLATCH,
  input  logic [1:0]       R_WL,
  input  logic             R_PME,
  input  logic [1:0]       R_PMC,
  input  logic             R_SBN,
  input  logic             R_BRK,
  output logic             TX,
  output logic             TXFULL,
  output logic             TXEMPTY,
  output logic             TXBUSY,
  output logic [LVL_W-1:0] TX_LEVEL,
  output logic             OVERRUN
);

  localparam int            TW         = $clog2(2 * OVERSAMPLE) + 1;
  localparam logic [TW-1:0] C_BIT_LAST = TW'(OVERSAMPLE - 1);

  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] r_stop_last;
  logic [7:0]    r_shift;
  logic [3:0]    r_bitcnt;
  logic [3:0]    r_nbits_last;
  logic          r_par;
  logic          r_pme;
  logic [1:0]    r_pmc;
  logic          r_tx;
  logic          r_ovr;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_brk;
  logic          w_pop;
  logic          w_push;
  logic          w_par_final;
  logic          w_par_bit;

`ifdef ACIA_TX_BREAK_EN
  logic          r_brk_mark;
  assign w_brk = R_BRK;
`else
  logic          w_unused_brk;
  assign w_unused_brk = R_BRK;
  assign w_brk        = 1'b0;
`endif

  // Pop only on a tick, from IDLE or on the last STOP tick (gapless back-to-back).
  assign w_pop  = BCLK_EN && !w_empty && !CTSB && !w_brk &&
                  ((r_state == S_IDLE) || (r_state == S_STOP && r_tick == r_stop_last));
  assign w_push = TXLATCH && (!w_full || w_pop);

  acia_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (PHI2),
    .rst     (RESET),
    .i_push  (TXLATCH),
    .i_pop   (w_pop),
    .i_data  (TXDATA),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (TX_LEVEL)
  );

  assign w_par_final = r_par ^ r_shift[0];

  always_comb begin
    w_par_bit = 1'b1;
    case (r_pmc)
      PAR_ODD:  w_par_bit = ~w_par_final;
      PAR_EVEN: w_par_bit = w_par_final;
      PAR_MARK: w_par_bit = 1'b1;
      default:  w_par_bit = 1'b0;
    endcase
  end

  always_ff @(posedge PHI2) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_stop_last  <= '0;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_nbits_last <= '0;
      r_par        <= 1'b0;
      r_pme        <= 1'b0;
      r_pmc        <= '0;
      r_tx         <= 1'b1;
      r_ovr        <= 1'b0;
`ifdef ACIA_TX_BREAK_EN
      r_brk_mark   <= 1'b0;
`endif
    end else begin
      r_ovr <= TXLATCH && !w_push;
      if (w_pop) begin
        r_shift      <= w_head;
        r_nbits_last <= nbits_from_wl(R_WL) - 4'd1;
        r_pme        <= R_PME;
        r_pmc        <= R_PMC;
        r_stop_last  <= TW'(stop_ticks(R_SBN, R_WL, R_PME, OVERSAMPLE) - 1);
        r_bitcnt     <= '0;
        r_par        <= 1'b0;
        r_tick       <= '0;
        r_tx         <= 1'b0;
        r_state      <= S_START;
      end else if (BCLK_EN) begin
        case (r_state)
          S_IDLE: begin
            r_tx <= 1'b1;
`ifdef ACIA_TX_BREAK_EN
            if (R_BRK) begin
              r_state    <= S_BREAK;
              r_tx       <= 1'b0;
              r_tick     <= '0;
              r_brk_mark <= 1'b0;
            end
`endif
          end
          S_START: begin
            if (r_tick == C_BIT_LAST) begin
              r_tick  <= '0;
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
            end else r_tick <= r_tick + 1'b1;
          end
          S_DATA: begin
            if (r_tick == C_BIT_LAST) begin
              r_tick  <= '0;
              r_par   <= w_par_final;
              r_shift <= r_shift >> 1;
              if (r_bitcnt == r_nbits_last) begin
                r_state <= r_pme ? S_PARITY : S_STOP;
                r_tx    <= r_pme ? w_par_bit : 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_tx     <= r_shift[1];
              end
            end else r_tick <= r_tick + 1'b1;
          end
          S_PARITY: begin
            if (r_tick == C_BIT_LAST) begin
              r_tick  <= '0;
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else r_tick <= r_tick + 1'b1;
          end
          S_STOP: begin
            if (r_tick == r_stop_last) begin
              r_tick  <= '0;
              r_state <= S_IDLE;
`ifdef ACIA_TX_BREAK_EN
              if (R_BRK) begin
                r_state    <= S_BREAK;
                r_tx       <= 1'b0;
                r_brk_mark <= 1'b0;
              end
`endif
            end else r_tick <= r_tick + 1'b1;
          end
`ifdef ACIA_TX_BREAK_EN
          S_BREAK: begin
            if (!r_brk_mark) begin
              if (!R_BRK) begin
                r_brk_mark <= 1'b1;
                r_tx       <= 1'b1;
                r_tick     <= '0;
              end
            end else if (r_tick == C_BIT_LAST) begin
              r_tick     <= '0;
              r_brk_mark <= 1'b0;
              r_state    <= S_IDLE;
            end else r_tick <= r_tick + 1'b1;
          end
`endif
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TX      = r_tx;
  assign TXFULL  = w_full;
  assign TXEMPTY = w_empty;
  assign TXBUSY  = (r_state != S_IDLE);
  assign OVERRUN = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_acia_tx_fifo.sv
// ============================================================================
// tb_acia_tx_fifo : directed self-checking bench for acia_tx_fifo
//                   (OVERSAMPLE=16, FIFO_DEPTH=4). Rev 1.0
// ============================================================================
`default_nettype none

module tb_acia_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       bclk_en;
  logic       ctsb;
  logic [7:0] txdata;
  logic       txlatch;
  logic [1:0] r_wl;
  logic       r_pme;
  logic [1:0] r_pmc;
  logic       r_sbn;
  logic       r_brk;
  logic       tx, txfull, txempty, txbusy, overrun;
  logic [2:0] tx_level;

  int nvec  = 0;
  int nfail = 0;

  acia_tx_fifo #(.FIFO_DEPTH(4), .OVERSAMPLE(16), .LVL_W(3)) dut (
    .PHI2     (clk),
    .RESET    (rst),
    .BCLK_EN  (bclk_en),
    .CTSB     (ctsb),
    .TXDATA   (txdata),
    .TXLATCH  (txlatch),
    .R_WL     (r_wl),
    .R_PME    (r_pme),
    .R_PMC    (r_pmc),
    .R_SBN    (r_sbn),
    .R_BRK    (r_brk),
    .TX       (tx),
    .TXFULL   (txfull),
    .TXEMPTY  (txempty),
    .TXBUSY   (txbusy),
    .TX_LEVEL (tx_level),
    .OVERRUN  (overrun)
  );

  always #5 clk = ~clk;

  // Baud tick on every second clock; changes just after the edge.
  initial begin
    bclk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1 bclk_en = ~bclk_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    txdata  = d;
    txlatch = 1'b1;
    step();
    txlatch = 1'b0;
  endtask

  // Waits for a start bit, samples each bit mid-period, counts ticks to idle.
  task automatic measure(input int nsamp, output logic [15:0] bits, output int len,
                         output int pre, output logic tout);
    int t;
    int cyc;
    bits = '0; len = 0; pre = 0; tout = 1'b0; cyc = 0; t = 0;
    while (tx !== 1'b0) begin
      @(posedge clk);
      if (bclk_en) pre++;
      #1;
      cyc++;
      if (cyc > 20000) begin tout = 1'b1; return; end
    end
    forever begin
      @(posedge clk);
      if (bclk_en) begin
        t++;
        #1;
        if (t >= 8 && ((t - 8) % 16) == 0 && ((t - 8) / 16) < nsamp)
          bits[(t - 8) / 16] = tx;
      end else #1;
      if (txbusy === 1'b0) break;
      cyc++;
      if (cyc > 20000) begin tout = 1'b1; break; end
    end
    len = t;
  endtask

  logic [15:0] bits;
  int          len;
  int          pre;
  logic        tout;
  logic [31:0] e;
  int          n;

  initial begin
    rst = 1'b1; ctsb = 1'b0; txdata = '0; txlatch = 1'b0;
    r_wl = 2'b00; r_pme = 1'b0; r_pmc = 2'b00; r_sbn = 1'b0; r_brk = 1'b0;
    step(); step();
    chk("rst_tx", tx, 1);
    chk("rst_full", txfull, 0);
    chk("rst_empty", txempty, 1);
    chk("rst_busy", txbusy, 0);
    chk("rst_level", tx_level, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    step();

    // 8N1, 0x55
    push(8'h55);
    chk("lvl_push", tx_level, 1);
    measure(10, bits, len, pre, tout);
    chk("8n1_tout", tout, 0);
    chk("8n1_bits", bits, 16'h02AA);
    chk("8n1_len", len, 160);
    chk("8n1_empty", txempty, 1);

    // 7 bits, parity odd/even/mark/space on 0x41
    for (int m = 0; m < 4; m++) begin
      r_wl = 2'b01; r_pme = 1'b1; r_pmc = m[1:0];
      push(8'h41);
      measure(10, bits, len, pre, tout);
      e = ((m == 0) || (m == 2)) ? 32'h382 : 32'h282;
      chk($sformatf("par%0d_bits", m), bits, e);
      chk($sformatf("par%0d_len", m), len, 160);
    end

    // stop lengths: 5N1.5, 8P1 with SBN, 6N2
    r_sbn = 1'b1;
    r_wl = 2'b11; r_pme = 1'b0;
    push(8'h15);
    measure(0, bits, len, pre, tout);
    chk("stop15_len", len, 120);
    r_wl = 2'b00; r_pme = 1'b1;
    push(8'h15);
    measure(0, bits, len, pre, tout);
    chk("stop8p_len", len, 176);
    r_wl = 2'b10; r_pme = 1'b0;
    push(8'h15);
    measure(0, bits, len, pre, tout);
    chk("stop6_len", len, 144);

    // fill with CTS deasserted, overflow, then gapless drain
    r_wl = 2'b00; r_pme = 1'b0; r_sbn = 1'b0;
    ctsb = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("fill_full", txfull, 1);
    chk("fill_level", tx_level, 4);
    chk("fill_ovr", overrun, 0);
    push(8'h05);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_level", tx_level, 4);
    step();
    chk("ovr_clear", overrun, 0);
    ctsb = 1'b0;
    measure(10, bits, len, pre, tout);
    chk("b2b_tout", tout, 0);
    chk("b2b_bits", bits, 16'h0202);
    chk("b2b_len", len, 640);
    chk("b2b_empty", txempty, 1);
    chk("b2b_level", tx_level, 0);

    // push into a full FIFO on the same edge as a pop
    ctsb = 1'b1;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    n = 0;
    while (!bclk_en && n < 10) begin step(); n++; end
    ctsb = 1'b0; txdata = 8'hA4; txlatch = 1'b1;
    step();
    txlatch = 1'b0; ctsb = 1'b1;
    chk("pp_ovr", overrun, 0);
    chk("pp_level", tx_level, 4);
    chk("pp_full", txfull, 1);
    chk("pp_busy", txbusy, 1);

    // reset in the middle of bit 1 (a zero) of 0xA0
    repeat (80) step();
    chk("mid_tx_low", tx, 0);
    rst = 1'b1;
    step();
    chk("mr_tx", tx, 1);
    chk("mr_level", tx_level, 0);
    chk("mr_busy", txbusy, 0);
    chk("mr_empty", txempty, 1);
    rst = 1'b0; ctsb = 1'b0;
    step();

`ifdef ACIA_TX_BREAK_EN
    push(8'h5A);
    repeat (40) step();
    r_brk = 1'b1;
    push(8'h3C);
    repeat (400) step();
    chk("brk_tx", tx, 0);
    chk("brk_busy", txbusy, 1);
    chk("brk_level", tx_level, 1);
    r_brk = 1'b0;
    n = 0;
    while (tx !== 1'b1 && n < 200) begin step(); n++; end
    chk("brk_release", tx, 1);
    measure(10, bits, len, pre, tout);
    chk("brk_mark_len", ((pre == 16) || (pre == 17)), 1);
    chk("brk_next_bits", bits, 16'h0278);
    chk("brk_next_len", len, 160);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
